arb_puf_resp_ctrl: RTL and testbench
====================================

// Module: arb_puf_resp_ctrl
// PURPOSE
//  Receiving end of the arbiter-PUF delay chain built from challenge-steered swap stages.
//  Latches a challenge, drives it onto the stage select lines, clears the end-of-chain
//  arbiter latch and launches the race edge. Samples the arbiter decision and repeats
//  the race EVALS times, then presents the majority-voted response bit over a
//  valid/ack handshake.
// PARAMETERS
//  N_STAGES   64  challenge width = number of swap stages in the chain
//  SETTLE_CYC 4   cycles held in each of CLEAR and FIRE before moving on (>=1)
//  EVALS      7   races per response; must be odd, >=1
//  CNT_W      $clog2(EVALS+1)  width of vote/eval counters (derived, do not override)
// PORTS
//  CLK        in   1         single clock, rising edge
//  RST_N      in   1         asynchronous active-low reset
//  START      in   1         request evaluation; accepted only in IDLE
//  CHAL       in   N_STAGES  challenge, captured on the accepted START cycle
//  CHAL_OUT   out  N_STAGES  registered challenge to the stage select inputs
//  ARB_CLR    out  1         clear for the arbiter latch, active high
//  LAUNCH     out  1         race edge into both chain inputs
//  ARB_IN     in   1         arbiter latch output, asynchronous to CLK
//  BUSY       out  1         high from accepted START until RESP_ACK handshake
//  RESP       out  1         majority-voted response bit
//  RESP_VALID out  1         RESP valid; held until acknowledged
//  RESP_ACK   in   1         consumer acknowledge
//  ONES_CNT   out  CNT_W     number of races that resolved to 1
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, CHAL_OUT=0, LAUNCH=0, ARB_CLR=1, BUSY=0, RESP=0,
//   RESP_VALID=0, ONES_CNT=0, counters=0, sync flops=0. Reset mid-race aborts with no output.
//  ARB_IN passes through a 2-flop synchronizer; only the synchronized value is used.
//  FSM:
//   IDLE : ARB_CLR=1, LAUNCH=0. START=1 -> capture CHAL into CHAL_OUT, clear ONES_CNT
//          and eval count, BUSY=1 -> CLEAR.
//   CLEAR: ARB_CLR=1, LAUNCH=0 for SETTLE_CYC cycles -> FIRE.
//   FIRE : ARB_CLR=0, LAUNCH=1 for SETTLE_CYC+2 cycles (covers synchronizer) -> SAMPLE.
//   SAMPLE (1 cycle): ONES_CNT += sync ARB; eval count += 1; LAUNCH stays 1.
//          Eval count == EVALS -> DONE, else -> CLEAR.
//   DONE : LAUNCH=0, ARB_CLR=1; RESP = (ONES_CNT > EVALS/2), RESP_VALID=1.
//          RESP_ACK=1 -> RESP_VALID=0, BUSY=0 -> IDLE on the next cycle.
//  Latency: RESP_VALID rises EVALS*(2*SETTLE_CYC+3)+1 cycles after START accepted.
//  CHAL_OUT is constant from capture until the next accepted START.
//  START while BUSY is ignored. RESP_ACK outside DONE is ignored.
//  START and RESP_ACK in the same DONE cycle: the ack completes; START is not accepted
//   (IDLE must be seen first).
//  RESP, ONES_CNT hold their last values in IDLE until the next START.
//  ONES_CNT never exceeds EVALS; no wrap is possible.
//  EVALS=1: single race; RESP equals the sampled arbiter bit.
// CONFIGURATION
//  ARB_STABILITY_FLAG_EN defined: adds output UNSTABLE (1 bit, reset 0), driven in DONE as
//   (ONES_CNT != 0 && ONES_CNT != EVALS); it is valid with RESP_VALID and holds until the next START.
//  ARB_STABILITY_FLAG_EN undefined: no UNSTABLE port and no related logic; all else identical.
// TESTING (SETTLE_CYC=4, EVALS=7 unless noted)
//  1 Use CHAL=64'hA5A5_0000_FFFF_1234 with ARB_IN tied 1. Pulse START.
//    -> CHAL_OUT=A5A5_0000_FFFF_1234 next cycle; RESP_VALID rises 78 cycles after START;
//       RESP=1, ONES_CNT=7.
//  2 Drive ARB_IN=1 on races 1,3,5 and 0 otherwise.
//    -> ONES_CNT=3, RESP=0; UNSTABLE=1 when the macro is defined.
//  3 Pulse START again while BUSY.
//    -> no restart; CHAL_OUT unchanged; latency still 78.
//  4 Hold RESP_ACK=0 for 20 cycles in DONE.
//    -> RESP_VALID and RESP stable. Assert RESP_ACK -> RESP_VALID=0 and BUSY=0 on the next cycle.
//  5 Drop RST_N to 0 during FIRE of race 4.
//    -> immediately LAUNCH=0, ARB_CLR=1, BUSY=0, ONES_CNT=0, RESP_VALID=0.
//  6 Run with EVALS=1 and ARB_IN=0.
//    -> RESP_VALID 12 cycles after START; RESP=0, ONES_CNT=0.

Source files
------------

// File: rtl/arb_puf_resp_ctrl.sv
// arb_puf_resp_ctrl
// Receiving-end controller for an arbiter-PUF swap-stage delay chain.
// Latches a challenge, runs EVALS clear/launch/sample races against the
// end-of-chain arbiter latch, and presents the majority-voted response over
// a valid/ack handshake.
// Optional feature macro: ARB_STABILITY_FLAG_EN adds the UNSTABLE output,
// flagging a response whose races did not all agree.
module arb_puf_resp_ctrl #(
  parameter int N_STAGES   = 64,
  parameter int SETTLE_CYC = 4,
  parameter int EVALS      = 7,
  localparam int CNT_W     = $clog2(EVALS + 1)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [N_STAGES-1:0] CHAL,
  output logic [N_STAGES-1:0] CHAL_OUT,
  output logic                ARB_CLR,
  output logic                LAUNCH,
  input  logic                ARB_IN,
  output logic                BUSY,
  output logic                RESP,
  output logic                RESP_VALID,
  input  logic                RESP_ACK,
  output logic [CNT_W-1:0]    ONES_CNT
`ifdef ARB_STABILITY_FLAG_EN
  ,
  output logic                UNSTABLE
`endif
);

  // Timer spans the longer of the two hold phases (FIRE: SETTLE_CYC+2 cycles).
  localparam int TMR_W = $clog2(SETTLE_CYC + 3);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FIRE,
    SAMPLE,
    DONE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] eval_cnt;
  logic             arb_sync_p0;
  logic             arb_sync_p1;

  // Two-flop synchronizer: the arbiter latch resolves asynchronously to CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arb_sync_p0 <= 1'b0;
      arb_sync_p1 <= 1'b0;
    end else begin
      arb_sync_p0 <= ARB_IN;
      arb_sync_p1 <= arb_sync_p0;
    end
  end

  // Race sequencer with registered outputs; each output changes together with
  // the state it belongs to, so the pins always reflect the current phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      tmr        <= '0;
      eval_cnt   <= '0;
      CHAL_OUT   <= '0;
      ARB_CLR    <= 1'b1;
      LAUNCH     <= 1'b0;
      BUSY       <= 1'b0;
      RESP       <= 1'b0;
      RESP_VALID <= 1'b0;
      ONES_CNT   <= '0;
`ifdef ARB_STABILITY_FLAG_EN
      UNSTABLE   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ARB_CLR <= 1'b1;
          LAUNCH  <= 1'b0;
          if (START) begin
            CHAL_OUT <= CHAL;
            ONES_CNT <= '0;
            eval_cnt <= '0;
            tmr      <= '0;
            BUSY     <= 1'b1;
`ifdef ARB_STABILITY_FLAG_EN
            UNSTABLE <= 1'b0;
`endif
            state    <= CLEAR;
          end
        end

        CLEAR: begin
          if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
            tmr     <= '0;
            ARB_CLR <= 1'b0;
            LAUNCH  <= 1'b1;
            state   <= FIRE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        // Two extra cycles let the decision travel through the synchronizer.
        FIRE: begin
          if (tmr == TMR_W'(SETTLE_CYC + 1)) begin
            tmr   <= '0;
            state <= SAMPLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        SAMPLE: begin
          ONES_CNT <= ONES_CNT + CNT_W'(arb_sync_p1);
          eval_cnt <= eval_cnt + 1'b1;
          LAUNCH   <= 1'b0;
          ARB_CLR  <= 1'b1;
          if (eval_cnt == CNT_W'(EVALS - 1)) begin
            state <= DONE;
          end else begin
            state <= CLEAR;
          end
        end

        // Vote is formed one cycle after the last sample, once ONES_CNT is final.
        DONE: begin
          LAUNCH     <= 1'b0;
          ARB_CLR    <= 1'b1;
          RESP       <= (ONES_CNT > CNT_W'(EVALS / 2));
          RESP_VALID <= 1'b1;
`ifdef ARB_STABILITY_FLAG_EN
          UNSTABLE   <= (ONES_CNT != '0) && (ONES_CNT != CNT_W'(EVALS));
`endif
          if (RESP_VALID && RESP_ACK) begin
            RESP_VALID <= 1'b0;
            BUSY       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_puf_resp_ctrl.sv
// tb_arb_puf_resp_ctrl
// Directed bench for arb_puf_resp_ctrl. A timeline model derived from the
// phase lengths (CLEAR, FIRE, SAMPLE per race, then DONE) predicts every
// output on every cycle of a transaction; literal expectations pin the model.
module tb_arb_puf_resp_ctrl;

  localparam int N   = 64;
  localparam int S   = 4;
  localparam int EV  = 7;
  localparam int P   = 2 * S + 3;
  localparam int CW  = $clog2(EV + 1);

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [N-1:0]  CHAL;
  logic [N-1:0]  CHAL_OUT;
  logic          ARB_CLR;
  logic          LAUNCH;
  logic          ARB_IN;
  logic          BUSY;
  logic          RESP;
  logic          RESP_VALID;
  logic          RESP_ACK;
  logic [CW-1:0] ONES_CNT;
`ifdef ARB_STABILITY_FLAG_EN
  logic          UNSTABLE;
  logic          unstable1;
`endif

  logic          start1;
  logic [N-1:0]  chal1;
  logic [N-1:0]  chal_out1;
  logic          clr1;
  logic          launch1;
  logic          arb1;
  logic          busy1;
  logic          resp1;
  logic          valid1;
  logic          ack1;
  logic [0:0]    ones1;

  arb_puf_resp_ctrl #(.N_STAGES(N), .SETTLE_CYC(S), .EVALS(EV)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .CHAL(CHAL), .CHAL_OUT(CHAL_OUT),
    .ARB_CLR(ARB_CLR), .LAUNCH(LAUNCH), .ARB_IN(ARB_IN), .BUSY(BUSY),
    .RESP(RESP), .RESP_VALID(RESP_VALID), .RESP_ACK(RESP_ACK), .ONES_CNT(ONES_CNT)
`ifdef ARB_STABILITY_FLAG_EN
    , .UNSTABLE(UNSTABLE)
`endif
  );

  arb_puf_resp_ctrl #(.N_STAGES(N), .SETTLE_CYC(S), .EVALS(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(start1), .CHAL(chal1), .CHAL_OUT(chal_out1),
    .ARB_CLR(clr1), .LAUNCH(launch1), .ARB_IN(arb1), .BUSY(busy1),
    .RESP(resp1), .RESP_VALID(valid1), .RESP_ACK(ack1), .ONES_CNT(ones1)
`ifdef ARB_STABILITY_FLAG_EN
    , .UNSTABLE(unstable1)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state for the transaction in flight
  bit          trk = 1'b0;
  bit          acked = 1'b0;
  int          start_cyc = 0;
  logic [N-1:0] exp_chal = '0;
  logic [6:0]  exp_pat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ones_upto(input logic [6:0] p, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(p[i]);
    return s;
  endfunction

  // Per-cycle comparison against the timeline model
  always @(negedge CLK) begin : cmp
    int c;
    int tot;
    bit vld;
    if (trk) begin
      c   = cyc - start_cyc;
      tot = ones_upto(exp_pat, EV);
      vld = 1'b0;
      chk("m_chal_out", CHAL_OUT, exp_chal);
      if (acked) begin
        chk("m_busy", BUSY, 0);
        chk("m_launch", LAUNCH, 0);
        chk("m_arb_clr", ARB_CLR, 1);
        chk("m_valid", RESP_VALID, 0);
        chk("m_ones", ONES_CNT, tot);
        chk("m_resp_hold", RESP, (tot > EV / 2));
      end else if (c < EV * P) begin
        chk("m_busy", BUSY, 1);
        chk("m_launch", LAUNCH, (c % P) >= S);
        chk("m_arb_clr", ARB_CLR, (c % P) < S);
        chk("m_valid", RESP_VALID, 0);
        chk("m_ones", ONES_CNT, ones_upto(exp_pat, c / P));
      end else begin
        vld = (c >= EV * P + 1);
        chk("m_busy", BUSY, 1);
        chk("m_launch", LAUNCH, 0);
        chk("m_arb_clr", ARB_CLR, 1);
        chk("m_ones", ONES_CNT, tot);
        chk("m_valid", RESP_VALID, vld);
        if (vld) chk("m_resp", RESP, (tot > EV / 2));
      end
`ifdef ARB_STABILITY_FLAG_EN
      if (acked || vld) chk("m_unstable", UNSTABLE, (tot != 0) && (tot != EV));
`endif
    end
  end

  task automatic run(input logic [N-1:0] chal, input logic [6:0] pat, input int hold,
                     input bit busy_start, input bit start_with_ack,
                     input int lit_ones, input bit lit_resp, input bit lit_unst);
    int lat;
    @(posedge CLK); #1;
    START = 1'b1; CHAL = chal; ARB_IN = pat[0];
    @(posedge CLK); #1;
    START = 1'b0; CHAL = ~chal;
    start_cyc = cyc; exp_chal = chal; exp_pat = pat; acked = 1'b0; trk = 1'b1;
    chk("chal_capture", CHAL_OUT, chal);
    for (int k = 0; k < EV; k++) begin
      ARB_IN = pat[k];
      for (int j = 0; j < P; j++) begin
        if (busy_start && k == 1 && j == 0) begin
          START = 1'b1; CHAL = 64'hDEAD_BEEF_0BAD_F00D;
        end
        @(posedge CLK); #1;
        START = 1'b0;
      end
    end
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (RESP_VALID) begin
        lat = cyc - start_cyc;
        break;
      end
      @(posedge CLK); #1;
    end
    chk("latency", lat, 78);
    chk("resp", RESP, lit_resp);
    chk("ones_cnt", ONES_CNT, lit_ones);
`ifdef ARB_STABILITY_FLAG_EN
    chk("unstable", UNSTABLE, lit_unst);
`else
    if (lit_unst) chk("unstable_lit_unused", 0, 0 + lit_unst - lit_unst);
`endif
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    chk("valid_held", RESP_VALID, 1);
    chk("resp_held", RESP, lit_resp);
    RESP_ACK = 1'b1;
    if (start_with_ack) begin
      START = 1'b1; CHAL = 64'h1111_2222_3333_4444;
    end
    @(posedge CLK); #1;
    RESP_ACK = 1'b0; START = 1'b0; acked = 1'b1;
    chk("ack_valid", RESP_VALID, 0);
    chk("ack_busy", BUSY, 0);
    @(posedge CLK); #1;
    chk("idle_busy", BUSY, 0);
    chk("idle_chal", CHAL_OUT, chal);
    trk = 1'b0;
  endtask

  initial begin
    int lat1;
    int s1;
    RST_N = 1'b0; START = 1'b0; CHAL = '0; ARB_IN = 1'b0; RESP_ACK = 1'b0;
    start1 = 1'b0; chal1 = '0; arb1 = 1'b0; ack1 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_arb_clr", ARB_CLR, 1);
    chk("rst_launch", LAUNCH, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", RESP_VALID, 0);
    chk("rst_resp", RESP, 0);
    chk("rst_ones", ONES_CNT, 0);
    chk("rst_chal", CHAL_OUT, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // All races resolve to 1; consumer stalls 20 cycles before acking
    run(64'hA5A5_0000_FFFF_1234, 7'b1111111, 20, 1'b0, 1'b0, 7, 1'b1, 1'b0);
    // Races 1,3,5 resolve to 1; START arrives together with the ack
    run(64'h0123_4567_89AB_CDEF, 7'b0010101, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    // START pulsed while busy must be ignored
    run(64'hFEDC_BA98_7654_3210, 7'b0001111, 2, 1'b1, 1'b0, 4, 1'b1, 1'b1);
    // All races resolve to 0
    run(64'h0000_0000_0000_0001, 7'b0000000, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Reset during FIRE of race 4
    @(posedge CLK); #1;
    START = 1'b1; CHAL = 64'hCAFE_F00D_1234_5678; ARB_IN = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    s1 = cyc;
    for (int i = 0; i < 200 && (cyc - s1) < 3 * P + S + 2; i++) begin
      @(posedge CLK); #1;
    end
    chk("pre_rst_launch", LAUNCH, 1);
    chk("pre_rst_ones", ONES_CNT, 3);
    RST_N = 1'b0;
    #1;
    chk("abort_launch", LAUNCH, 0);
    chk("abort_arb_clr", ARB_CLR, 1);
    chk("abort_busy", BUSY, 0);
    chk("abort_ones", ONES_CNT, 0);
    chk("abort_valid", RESP_VALID, 0);
    chk("abort_chal", CHAL_OUT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Recovery after abort: five of seven races high
    run(64'h5555_AAAA_5555_AAAA, 7'b1011011, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);

    // Single-race instance, arbiter held at 0
    @(posedge CLK); #1;
    start1 = 1'b1; chal1 = 64'h0F0F_0F0F_0F0F_0F0F;
    @(posedge CLK); #1;
    start1 = 1'b0;
    s1 = cyc;
    chk("e1_chal", chal_out1, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("e1_busy", busy1, 1);
    lat1 = -1;
    for (int i = 0; i < 40; i++) begin
      if (valid1) begin
        lat1 = cyc - s1;
        break;
      end
      @(posedge CLK); #1;
    end
    chk("e1_latency", lat1, 12);
    chk("e1_resp", resp1, 0);
    chk("e1_ones", ones1, 0);
    chk("e1_launch", launch1, 0);
    chk("e1_arb_clr", clr1, 1);
`ifdef ARB_STABILITY_FLAG_EN
    chk("e1_unstable", unstable1, 0);
`endif
    ack1 = 1'b1;
    @(posedge CLK); #1;
    ack1 = 1'b0;
    chk("e1_ack_valid", valid1, 0);
    chk("e1_ack_busy", busy1, 0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
